// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serialiser state encodings.
package uart_tx_mmio_pkg;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A programmed divisor of 0 behaves as 1 cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push into a full FIFO is accepted only when a pop
// happens on the same edge. Count is held separately from the wrapping pointers.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and serialiser.
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued byte
//   S_START | start bit (low) for one bit period
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (high); chains straight into S_START if bytes remain
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd868
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    Addr_i,
  input  logic          Read_en_i,
  output logic [DW-1:0] Read_data_o,
  input  logic          Write_en_i,
  input  logic [DW-1:0] Wr_data_i,
  output logic          tx_o,
  output logic          irq_o
);

  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   div_cnt_q, div_cnt_d;
  logic [15:0]   div_frame_q, div_frame_d;
  logic [15:0]   bauddiv_q, bauddiv_d;
  logic          ovf_q, ovf_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]                  fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        bit_tick, load_frame;
  logic [DW-1:0]               status;
  logic                        unused_wdata;

  assign unused_wdata = ^Wr_data_i[DW-1:16];
  assign fifo_push    = Write_en_i && (Addr_i == UART_TXDATA);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (Wr_data_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // tx_d follows the next state so the start bit appears on the pop edge itself.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    div_frame_d = div_frame_q;
    tx_d        = tx_q;
    bit_tick    = (state_q != S_IDLE) && (div_cnt_q == 16'd0);
    load_frame  = !fifo_empty &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_tick));
    fifo_pop    = load_frame;

    if (state_q != S_IDLE) begin
      div_cnt_d = bit_tick ? (div_frame_q - 16'd1) : (div_cnt_q - 16'd1);
    end

    if (bit_tick) begin
      case (state_q)
        S_START: begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end
        S_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    if (load_frame) begin
      state_d     = S_START;
      shift_d     = fifo_dout;
      div_frame_d = eff_div(bauddiv_q);
      div_cnt_d   = eff_div(bauddiv_q) - 16'd1;
      tx_d        = 1'b0;
    end
  end

  always_comb begin
    status                            = '0;
    status[ST_BUSY_BIT]               = (state_q != S_IDLE);
    status[ST_FULL_BIT]               = fifo_full;
    status[ST_EMPTY_BIT]              = fifo_empty;
    status[ST_OVF_BIT]                = ovf_q;
    status[ST_COUNT_LSB +: 4]         = 4'(fifo_count);

    bauddiv_d = bauddiv_q;
    ovf_d     = ovf_q;
    rdata_d   = rdata_q;
    irq_d     = fifo_empty && (state_q == S_IDLE);

    if (Write_en_i && (Addr_i == UART_BAUDDIV)) begin
      bauddiv_d = Wr_data_i[15:0];
    end
    if (Write_en_i && (Addr_i == UART_STATUS)) begin
      ovf_d = 1'b0;
    end
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end

    if (Read_en_i) begin
      case (Addr_i)
        UART_STATUS:  rdata_d = status;
        UART_BAUDDIV: rdata_d = DW'(bauddiv_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      div_frame_q <= 16'd1;
      bauddiv_q   <= DIV_RST;
      ovf_q       <= 1'b0;
      tx_q        <= 1'b1;
      irq_q       <= 1'b1;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      div_frame_q <= div_frame_d;
      bauddiv_q   <= bauddiv_d;
      ovf_q       <= ovf_d;
      tx_q        <= tx_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign tx_o        = tx_q;
  assign irq_o       = irq_q;
  assign Read_data_o = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio: register access, frame timing,
// back-to-back frames, FIFO overflow, zero divisor and mid-frame reset.
module tb_uart_tx_mmio;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  Addr_i = 2'd0;
  logic        Read_en_i = 1'b0;
  logic [31:0] Read_data_o;
  logic        Write_en_i = 1'b0;
  logic [31:0] Wr_data_i = 32'd0;
  logic        tx_o;
  logic        irq_o;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_mmio #(
    .DW         (32),
    .FIFO_DEPTH (4),
    .DIV_RST    (16'd868)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .Addr_i      (Addr_i),
    .Read_en_i   (Read_en_i),
    .Read_data_o (Read_data_o),
    .Write_en_i  (Write_en_i),
    .Wr_data_i   (Wr_data_i),
    .tx_o        (tx_o),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected line level for bit slot idx (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Bus helpers are entered at a negedge and return at the negedge after the access edge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    Addr_i     = addr;
    Wr_data_i  = data;
    Write_en_i = 1'b1;
    @(negedge clk_i);
    Write_en_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    Addr_i    = addr;
    Read_en_i = 1'b1;
    @(negedge clk_i);
    Read_en_i = 1'b0;
    data      = Read_data_o;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx_o); end
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL reset_irq got %b want 1", irq_o); end
    vectors++;
    if (Read_data_o !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", Read_data_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h4) begin miscompares++; $display("FAIL reset_status got %h want 00000004", rd); end
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd868) begin miscompares++; $display("FAIL reset_bauddiv got %0d want 868", rd); end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    bus_write(2'd2, 32'd4);
    Addr_i = 2'd0; Wr_data_i = 32'hA5; Write_en_i = 1'b1;
    @(negedge clk_i);
    Write_en_i = 1'b0;
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL single_pre_start got %b want 1", tx_o); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      vectors++;
      if (tx_o !== exp_bit(8'hA5, k / 4)) begin
        miscompares++; $display("FAIL single_tx k=%0d got %b want %b", k, tx_o, exp_bit(8'hA5, k / 4));
      end
      if (k == 8) begin
        vectors++;
        if (irq_o !== 1'b0) begin miscompares++; $display("FAIL single_irq_busy got %b want 0", irq_o); end
      end
    end
    repeat (2) @(negedge clk_i);
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL single_irq_done got %b want 1", irq_o); end
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h4) begin miscompares++; $display("FAIL single_status got %h want 00000004", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic       e;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    bus_write(2'd2, 32'd2);
    Addr_i = 2'd0; Wr_data_i = 32'h01; Write_en_i = 1'b1;
    @(negedge clk_i);
    Wr_data_i = 32'h02;
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL b2b_pre_start got %b want 1", tx_o); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      e = exp_bit(bytes[k / 20], (k % 20) / 2);
      vectors++;
      if (tx_o !== e) begin miscompares++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx_o, e); end
      if (k == 0) Wr_data_i = 32'h03;
      if (k == 1) begin
        Write_en_i = 1'b0;
        Addr_i = 2'd1; Read_en_i = 1'b1;
      end
      if (k == 2) begin
        Read_en_i = 1'b0;
        vectors++;
        if (Read_data_o !== 32'h21) begin miscompares++; $display("FAIL b2b_status_count got %h want 00000021", Read_data_o); end
      end
    end
    repeat (2) @(negedge clk_i);
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL b2b_irq_done got %b want 1", irq_o); end
  endtask

  task automatic test_overflow();
    logic [7:0]  bytes [5];
    logic [31:0] rd;
    logic        e;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    bus_write(2'd2, 32'd2);
    Addr_i = 2'd0; Wr_data_i = 32'h11; Write_en_i = 1'b1;
    @(negedge clk_i);
    Wr_data_i = 32'h22;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      e = exp_bit(bytes[k / 20], (k % 20) / 2);
      vectors++;
      if (tx_o !== e) begin miscompares++; $display("FAIL ovf_tx k=%0d got %b want %b", k, tx_o, e); end
      case (k)
        0: Wr_data_i = 32'h33;
        1: Wr_data_i = 32'h44;
        2: Wr_data_i = 32'h55;
        3: Wr_data_i = 32'h66;
        4: begin Write_en_i = 1'b0; Addr_i = 2'd1; Read_en_i = 1'b1; end
        5: begin
          Read_en_i = 1'b0;
          vectors++;
          if (Read_data_o !== 32'h4B) begin miscompares++; $display("FAIL ovf_status_set got %h want 0000004b", Read_data_o); end
          Wr_data_i = 32'h0; Write_en_i = 1'b1;
        end
        6: begin Write_en_i = 1'b0; Read_en_i = 1'b1; end
        7: begin
          Read_en_i = 1'b0;
          vectors++;
          if (Read_data_o !== 32'h43) begin miscompares++; $display("FAIL ovf_status_clr got %h want 00000043", Read_data_o); end
        end
        default: ;
      endcase
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      vectors++;
      if (tx_o !== 1'b1) begin miscompares++; $display("FAIL ovf_no_sixth k=%0d got %b want 1", k, tx_o); end
    end
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL ovf_irq_done got %b want 1", irq_o); end
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h4) begin miscompares++; $display("FAIL ovf_status_end got %h want 00000004", rd); end
  endtask

  task automatic test_div_zero();
    logic [31:0] rd;
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd0) begin miscompares++; $display("FAIL div0_readback got %0d want 0", rd); end
    bus_write(2'd0, 32'h80);
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL div0_pre_start got %b want 1", tx_o); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      vectors++;
      if (tx_o !== exp_bit(8'h80, (k < 10) ? k : 9)) begin
        miscompares++; $display("FAIL div0_tx k=%0d got %b want %b", k, tx_o, exp_bit(8'h80, (k < 10) ? k : 9));
      end
    end
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL div0_irq_done got %b want 1", irq_o); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    bus_write(2'd2, 32'd4);
    Addr_i = 2'd0; Wr_data_i = 32'hC3; Write_en_i = 1'b1;
    @(negedge clk_i);
    Wr_data_i = 32'h5A;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_i);
      vectors++;
      if (tx_o !== exp_bit(8'hC3, k / 4)) begin
        miscompares++; $display("FAIL rstmid_tx k=%0d got %b want %b", k, tx_o, exp_bit(8'hC3, k / 4));
      end
      if (k == 0) Wr_data_i = 32'h77;
      if (k == 1) Write_en_i = 1'b0;
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx_high got %b want 1", tx_o); end
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_irq got %b want 1", irq_o); end
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h4) begin miscompares++; $display("FAIL rstmid_status got %h want 00000004", rd); end
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd868) begin miscompares++; $display("FAIL rstmid_bauddiv got %0d want 868", rd); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      vectors++;
      if (tx_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle k=%0d got %b want 1", k, tx_o); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'd0) begin miscompares++; $display("FAIL regs_txdata_read got %h want 0", rd); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    vectors++;
    if (rd !== 32'd0) begin miscompares++; $display("FAIL regs_reserved got %h want 0", rd); end
    Addr_i = 2'd2; Wr_data_i = 32'h0003_0007; Write_en_i = 1'b1; Read_en_i = 1'b1;
    @(negedge clk_i);
    Write_en_i = 1'b0; Read_en_i = 1'b0;
    vectors++;
    if (Read_data_o !== 32'd868) begin miscompares++; $display("FAIL regs_rw_same got %0d want 868", Read_data_o); end
    @(negedge clk_i);
    vectors++;
    if (Read_data_o !== 32'd868) begin miscompares++; $display("FAIL regs_rdata_hold got %0d want 868", Read_data_o); end
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd7) begin miscompares++; $display("FAIL regs_bauddiv_new got %0d want 7", rd); end
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL regs_tx_idle got %b want 1", tx_o); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_div_zero();
    test_reset_mid_frame();
    test_regs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data bus, in parallel with the data memory (a downstream consumer of the core data port).
- The top-level address decode steers core stores/loads here; the block buffers bytes in a small FIFO and serialises them 8N1, LSB first.
- Its bus port timing matches the data memory, so the core needs no changes.

Parameters:
- DW, 32, data bus width (equals `dw).
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.
- DIV_RST, 16'd868, reset value of BAUDDIV (cycles per bit).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous active-low reset.
- Addr_i  in  2  word select (core data_addr[3:2]).
- Read_en_i  in  1  register read strobe.
- Read_data_o  out  DW  read data, registered.
- Write_en_i  in  1  register write strobe.
- Wr_data_i  in  DW  write data.
- tx_o  out  1  serial output, idle high.
- irq_o  out  1  level interrupt: FIFO empty and shifter idle.

Behaviour:
- Reset (rst_i==0 sampled at an edge):
  - FIFO emptied, FSM to IDLE, BAUDDIV=DIV_RST, overflow flag cleared.
  - Read_data_o=0, tx_o=1, irq_o=1.
  - Applies mid-frame: tx_o is 1 after the reset edge and the partial frame is abandoned.
- Register map (Addr_i):
  - 0 TXDATA: write pushes Wr_data_i[7:0]; reads return 0.
  - 1 STATUS, read-only except bit3:
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - [7:4] FIFO count
    - others 0
    - Any write to STATUS clears overflow.
  - 2 BAUDDIV: [15:0] R/W, upper bits read 0.
  - 3 reserved: reads 0, writes ignored.
- Read latency:
  - Read_data_o updates at the edge where Read_en_i=1 and holds its value otherwise.
  - Data valid one cycle after the strobe, same as the data memory.
- Read and write in the same cycle to the same register: the read returns the pre-write value.
- Push:
  - Accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH; count is a separate counter, 0..FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP:
  - IDLE -> START when FIFO not empty. The pop and the capture into the shift register happen on that edge. BAUDDIV is latched into the frame divisor on the same edge.
  - START: tx_o=0 for one bit period.
  - DATA: 8 bit periods, LSB first, tracked by a 3-bit bit counter.
  - STOP: tx_o=1 for one bit period.
  - Leaving STOP: go to START directly if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise go to IDLE.
- Bit period = latched divisor clock cycles; divisor 0 is treated as 1. The divider counter reloads at every bit boundary.
- BAUDDIV writes mid-frame take effect on the next frame only.
- tx_o is registered from FSM state and the shift register (no glitches).
- Frame length = 10 × divisor cycles.
- First tx_o falling edge is 2 cycles after the TXDATA write edge into an empty idle block: push edge, then pop/START edge.
- irq_o = empty && IDLE, registered.

Decomposition:
- Shared package/header additions:
  - register offsets UART_TXDATA=2'd0, UART_STATUS=2'd1, UART_BAUDDIV=2'd2
  - STATUS bit positions
  - FSM state encodings (2-bit localparams)
- One sub-module: uart_tx_fifo (synchronous FIFO, depth/width parameters, push/pop/full/empty/count).
- Bus decode and the serialiser FSM remain in uart_tx_mmio.

Test Plan:
- Reset then read STATUS → Read_data_o=0x04 one cycle later, tx_o=1, irq_o=1. Read BAUDDIV → 868.
- BAUDDIV=4, write TXDATA=0xA5 → tx_o pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; start bit begins 2 cycles after the write; irq_o returns to 1 after the stop bit.
- BAUDDIV=2, write 0x01, 0x02, 0x03 back-to-back → three contiguous 20-cycle frames with no idle gap. STATUS count reads 2 immediately after the third write.
- Fill FIFO (4 pushes) while a frame is shifting, push a 5th → byte dropped, STATUS bit3=1. Write STATUS → bit3=0. Only 5 frames total are sent.
- BAUDDIV=0, write 0x80 → 10-cycle frame (1 cycle per bit).
- rst_i low mid-DATA of a frame with 2 bytes queued → tx_o=1 next edge, STATUS=0x04, no further frames.
